// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter_if
// Brief    : Producer request bus plus single-entry fifo write port.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 16
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic                          fifo_full;
   logic                          fifo_fault;
   logic                          fifo_write_strobe;
   logic [DATA_WIDTH-1:0]         fifo_write_data;
   logic [ID_WIDTH-1:0]           grant_id;
   logic                          busy;
   logic                          error;

   // Environment side: producers and the fifo.
   modport master (
      output req, req_data, fifo_full, fifo_fault,
      input  ack, fifo_write_strobe, fifo_write_data, grant_id, busy, error
   );

   // Arbiter side.
   modport slave (
      input  req, req_data, fifo_full, fifo_fault,
      output ack, fifo_write_strobe, fifo_write_data, grant_id, busy, error
   );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Brief    : Round-robin arbiter pacing NUM_REQ producers onto one fifo slot.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 16
) (
   input  wire logic           clk,
   input  wire logic           rst,
   fifo_write_arbiter_if.slave bus
);

   localparam logic [ID_WIDTH:0] c_NUM_REQ = (ID_WIDTH+1)'(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HALT   = 2'd2
   } state_t;

   state_t                  r_state;
   logic [ID_WIDTH-1:0]     r_ptr;
   logic                    r_strobe;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [NUM_REQ-1:0]      r_ack;
   logic [ID_WIDTH-1:0]     r_grant_id;
   logic                    r_busy;
   logic                    r_error;

   logic [2*NUM_REQ-1:0]    w_req_dbl;
   logic [NUM_REQ-1:0]      w_req_rot;
   logic [ID_WIDTH:0]       w_off;
   logic [ID_WIDTH:0]       w_sum;
   logic [ID_WIDTH:0]       w_next;
   logic [ID_WIDTH-1:0]     w_winner;
   logic [ID_WIDTH-1:0]     w_ptr_next;
   logic                    w_any;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [NUM_REQ-1:0]      w_ack_oh;

   // Rotate requests so the pointer position lands at bit 0, then take the lowest set bit.
   assign w_req_dbl = {bus.req, bus.req};
   assign w_req_rot = NUM_REQ'(w_req_dbl >> r_ptr);
   assign w_any     = |bus.req;

   always_comb begin
      w_off = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (w_req_rot[j]) begin
            w_off = (ID_WIDTH+1)'(j);
         end
      end
   end

   assign w_sum      = {1'b0, r_ptr} + w_off;
   assign w_winner   = ID_WIDTH'((w_sum >= c_NUM_REQ) ? (w_sum - c_NUM_REQ) : w_sum);
   assign w_next     = {1'b0, w_winner} + (ID_WIDTH+1)'(1);
   assign w_ptr_next = (w_next >= c_NUM_REQ) ? '0 : ID_WIDTH'(w_next);

   always_comb begin
      w_data   = '0;
      w_ack_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner == ID_WIDTH'(i)) begin
            w_data      = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            w_ack_oh[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_strobe   <= 1'b0;
         r_wdata    <= '0;
         r_ack      <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.fifo_fault) begin
                  r_state <= S_HALT;
                  r_error <= 1'b1;
               end else if (!bus.fifo_full && w_any) begin
                  r_strobe   <= 1'b1;
                  r_wdata    <= w_data;
                  r_ack      <= w_ack_oh;
                  r_grant_id <= w_winner;
                  r_ptr      <= w_ptr_next;
                  r_busy     <= 1'b1;
                  r_state    <= S_SETTLE;
               end
            end
            // fifo_full is stale here: the fifo has not yet registered this write.
            S_SETTLE: begin
               r_strobe <= 1'b0;
               r_ack    <= '0;
               r_busy   <= 1'b0;
               if (bus.fifo_fault) begin
                  r_state <= S_HALT;
                  r_error <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_HALT: begin
               r_strobe <= 1'b0;
               r_ack    <= '0;
               r_busy   <= 1'b0;
               r_error  <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.fifo_write_strobe = r_strobe;
   assign bus.fifo_write_data   = r_wdata;
   assign bus.ack               = r_ack;
   assign bus.grant_id          = r_grant_id;
   assign bus.busy              = r_busy;
   assign bus.error             = r_error;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Brief    : Self-checking bench with a single-entry fifo and a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int ID_WIDTH   = 2;
   localparam int DATA_WIDTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

   fifo_write_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   logic cons_ready;
   logic force_fault;
   logic fifo_full_r;
   int   overflow_cnt = 0;
   int   grant_q[$];

   assign bus.fifo_full  = fifo_full_r;
   assign bus.fifo_fault = force_fault;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Single-entry fifo with a registered full flag; consumer pops when cons_ready.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_full_r <= 1'b0;
      end else begin
         if (bus.fifo_write_strobe && fifo_full_r && !cons_ready)
            overflow_cnt <= overflow_cnt + 1;
         if (bus.fifo_write_strobe)
            fifo_full_r <= 1'b1;
         else if (cons_ready)
            fifo_full_r <= 1'b0;
      end
   end

   // Reference model: a grant is a cyclic search from the pointer; a write
   // blocks granting for the following cycle; any fault halts forever.
   logic                  e_strobe, e_busy, e_err;
   logic [NUM_REQ-1:0]    e_ack;
   logic [DATA_WIDTH-1:0] e_data;
   logic [ID_WIDTH-1:0]   e_gid;
   int                    m_ptr;
   bit                    m_halt;
   int                    m_win;

   function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
      end
      return 0;
   endfunction

   always_comb m_win = pick(bus.req, m_ptr);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_strobe <= 1'b0; e_busy <= 1'b0; e_err <= 1'b0;
         e_ack <= '0; e_data <= '0; e_gid <= '0;
         m_ptr <= 0; m_halt <= 1'b0;
      end else if (m_halt) begin
         e_strobe <= 1'b0;
      end else if (e_strobe) begin
         e_strobe <= 1'b0; e_ack <= '0; e_busy <= 1'b0;
         if (bus.fifo_fault) begin m_halt <= 1'b1; e_err <= 1'b1; end
      end else if (bus.fifo_fault) begin
         m_halt <= 1'b1; e_err <= 1'b1;
      end else if (!bus.fifo_full && bus.req != '0) begin
         e_strobe <= 1'b1;
         e_ack    <= NUM_REQ'(1 << m_win);
         e_data   <= bus.req_data[m_win*DATA_WIDTH +: DATA_WIDTH];
         e_gid    <= ID_WIDTH'(m_win);
         e_busy   <= 1'b1;
         m_ptr    <= (m_win + 1) % NUM_REQ;
      end
   end

   logic prev_strobe;
   always @(negedge clk) begin
      if (!rst) begin
         chk("strobe",   32'(bus.fifo_write_strobe), 32'(e_strobe));
         chk("ack",      32'(bus.ack),               32'(e_ack));
         chk("wdata",    32'(bus.fifo_write_data),   32'(e_data));
         chk("grant_id", 32'(bus.grant_id),          32'(e_gid));
         chk("busy",     32'(bus.busy),              32'(e_busy));
         chk("error",    32'(bus.error),             32'(e_err));
         chk("no_b2b",   32'(prev_strobe & bus.fifo_write_strobe), 32'(0));
         if (bus.fifo_write_strobe) grant_q.push_back(int'(bus.grant_id));
         prev_strobe <= bus.fifo_write_strobe;
      end else begin
         prev_strobe <= 1'b0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [DATA_WIDTH-1:0] v);
      bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = v;
   endtask

   task automatic do_reset();
      bus.req = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_not_full(input string name);
      int n = 0;
      while (fifo_full_r && n < 30) begin
         tick();
         n++;
      end
      chk(name, 32'(fifo_full_r), 32'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      int exp_rr[5] = '{0, 1, 2, 3, 0};
      bus.req = '0; bus.req_data = '0;
      cons_ready = 1'b1; force_fault = 1'b0; rst = 1'b1;
      tick(); tick();
      chk("rst_strobe", 32'(bus.fifo_write_strobe), 0);
      chk("rst_ack",    32'(bus.ack), 0);
      chk("rst_data",   32'(bus.fifo_write_data), 0);
      chk("rst_gid",    32'(bus.grant_id), 0);
      chk("rst_busy",   32'(bus.busy), 0);
      chk("rst_error",  32'(bus.error), 0);
      rst = 1'b0;
      tick();

      // Single request
      set_data(1, 16'hBEEF);
      bus.req = 4'b0010;
      tick();
      chk("single_strobe", 32'(bus.fifo_write_strobe), 1);
      chk("single_ack",    32'(bus.ack), 32'h2);
      chk("single_data",   32'(bus.fifo_write_data), 32'hBEEF);
      chk("single_gid",    32'(bus.grant_id), 1);
      chk("single_busy",   32'(bus.busy), 1);
      bus.req = '0;
      tick();
      chk("single_busy_drop", 32'(bus.busy), 0);
      tick(); tick();

      // Round robin with an always-ready consumer
      do_reset();
      grant_q.delete();
      for (int i = 0; i < NUM_REQ; i++) set_data(i, DATA_WIDTH'(16'h1000 + i));
      bus.req = 4'b1111;
      repeat (18) tick();
      chk("rr_count", 32'(grant_q.size() >= 5), 1);
      if (grant_q.size() >= 5)
         for (int i = 0; i < 5; i++) chk("rr_order", 32'(grant_q[i]), 32'(exp_rr[i]));
      bus.req = '0;
      repeat (3) tick();

      // Full back-pressure
      do_reset();
      cons_ready = 1'b0;
      set_data(2, 16'h1111);
      bus.req = 4'b0100;
      tick();
      chk("bp_first", 32'(bus.fifo_write_strobe), 1);
      set_data(2, 16'h2222);
      n = 0;
      repeat (10) begin
         tick();
         if (bus.fifo_write_strobe) n++;
      end
      chk("bp_stall_strobes", 32'(n), 0);
      chk("bp_full_held", 32'(fifo_full_r), 1);
      cons_ready = 1'b1;
      wait_not_full("bp_full_drop");
      chk("bp_no_strobe_at_drop", 32'(bus.fifo_write_strobe), 0);
      tick();
      chk("bp_grant_after_drop", 32'(bus.fifo_write_strobe), 1);
      chk("bp_ack",  32'(bus.ack), 32'h4);
      chk("bp_data", 32'(bus.fifo_write_data), 32'h2222);
      bus.req = '0;
      repeat (3) tick();
      chk("bp_no_overflow", 32'(overflow_cnt), 0);

      // Fault halt, then reset must restore pointer 0
      do_reset();
      set_data(2, 16'h3333);
      bus.req = 4'b0100;
      tick();
      bus.req = '0;
      repeat (3) tick();
      set_data(0, 16'h4444);
      bus.req = 4'b0001;
      force_fault = 1'b1;
      tick();
      force_fault = 1'b0;
      chk("fault_err",       32'(bus.error), 1);
      chk("fault_no_strobe", 32'(bus.fifo_write_strobe), 0);
      n = 0;
      repeat (6) begin
         tick();
         if (bus.fifo_write_strobe || bus.ack != '0) n++;
      end
      chk("halt_no_grant",   32'(n), 0);
      chk("halt_err_sticky", 32'(bus.error), 1);
      chk("halt_data_held",  32'(bus.fifo_write_data), 32'h3333);
      rst = 1'b1;
      #1;
      chk("rst_clears_err", 32'(bus.error), 0);
      tick();
      rst = 1'b0;
      set_data(3, 16'h5555);
      bus.req = 4'b1001;
      tick();
      chk("post_fault_gid", 32'(bus.grant_id), 0);
      chk("post_fault_ack", 32'(bus.ack), 32'h1);
      bus.req = '0;
      repeat (3) tick();

      // Asynchronous reset during the settle cycle
      do_reset();
      set_data(2, 16'h6666);
      bus.req = 4'b0100;
      tick();
      bus.req = '0;
      repeat (3) tick();
      set_data(2, 16'h7777);
      bus.req = 4'b0100;
      tick();
      chk("mid_strobe_pre", 32'(bus.fifo_write_strobe), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_strobe_drop", 32'(bus.fifo_write_strobe), 0);
      chk("mid_ack_drop",    32'(bus.ack), 0);
      chk("mid_busy_drop",   32'(bus.busy), 0);
      tick();
      rst = 1'b0;
      set_data(1, 16'h8888);
      set_data(3, 16'h9999);
      bus.req = 4'b1010;
      tick();
      chk("mid_post_gid",  32'(bus.grant_id), 1);
      chk("mid_post_ack",  32'(bus.ack), 32'h2);
      chk("mid_post_data", 32'(bus.fifo_write_data), 32'h8888);
      bus.req = '0;
      repeat (3) tick();

      // Withdrawn request
      do_reset();
      set_data(0, 16'hAAAA);
      bus.req = 4'b0001;
      tick();
      cons_ready = 1'b0;
      set_data(0, 16'hBBBB);
      set_data(1, 16'hCCCC);
      bus.req = 4'b0011;
      tick(); tick();
      bus.req = 4'b0001;
      cons_ready = 1'b1;
      wait_not_full("wd_full_drop");
      tick();
      chk("wd_gid",  32'(bus.grant_id), 0);
      chk("wd_ack",  32'(bus.ack), 32'h1);
      chk("wd_data", 32'(bus.fifo_write_data), 32'hBBBB);
      bus.req = '0;
      repeat (3) tick();
      bus.req = 4'b0011;
      tick();
      chk("wd_ptr_after", 32'(bus.grant_id), 1);
      bus.req = '0;
      repeat (3) tick();

      // Randomized traffic, ending with one fault
      do_reset();
      grant_q.delete();
      for (int c = 0; c < 600; c++) begin
         tick();
         force_fault = (c == 560);
         cons_ready  = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i]) begin
               if (bus.ack[i]) begin
                  if ($urandom_range(0, 1) == 1) set_data(i, DATA_WIDTH'($urandom));
                  else bus.req[i] = 1'b0;
               end else if ($urandom_range(0, 15) == 0) begin
                  bus.req[i] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               set_data(i, DATA_WIDTH'($urandom));
               bus.req[i] = 1'b1;
            end
         end
      end
      force_fault = 1'b0;
      tick();
      chk("rand_writes_seen", 32'(grant_q.size() > 20), 1);
      chk("rand_no_overflow", 32'(overflow_cnt), 0);
      chk("rand_halted",      32'(bus.error), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
